// File: rtl/dtof_acq_sequencer.sv
// Two-pass dToF acquisition sequencer: clear, coarse histogram, threshold wait,
// windowed fine histogram, then a valid/ack result handoff to readout.
module dtof_acq_sequencer #(
    parameter int unsigned NP        = 10,
    parameter int unsigned NB        = 5,
    parameter int unsigned CH_FRAMES = 4,
    parameter int unsigned FH_FRAMES = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic          abort,
    input  logic          laser_sync,
    input  logic          tdc_valid,
    input  logic [NP-1:0] tdc_data,
    output logic          hit_we,
    output logic [NP-1:0] hit_data,
    output logic          his_num,
    output logic          his_clr,
    output logic [NB-1:0] clr_addr,
    output logic          acq_count_finish,
    input  logic          peak_done,
    input  logic          alg_ready,
    input  logic [NP-1:0] th_minus,
    input  logic [NP-1:0] th_positive,
    input  logic [NB-1:0] peak_fh,
    output logic          busy,
    output logic          result_valid,
    input  logic          result_ack,
    output logic [NB-1:0] result_peak,
    output logic          result_err,
    output logic [15:0]   result_hits
);

    localparam int unsigned   WW        = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [15:0]   CH_LAST   = 16'(CH_FRAMES - 1);
    localparam logic [15:0]   FH_LAST   = 16'(FH_FRAMES - 1);
    localparam logic [NB-1:0] CLR_LAST  = '1;

    typedef enum logic [3:0] {
        IDLE, CLR_CH, CH_ACQ, CH_PK, CALC, CLR_FH, FH_ACQ, FH_PK, DONE
    } state_t;

    state_t        state, state_d;
    logic [15:0]   frame_cnt, frame_cnt_d;
    logic [WW-1:0] wait_cnt, wait_cnt_d;
    logic [NP-1:0] th_minus_q, th_minus_d;
    logic [NP-1:0] th_positive_q, th_positive_d;
    logic [NB-1:0] clr_addr_d;
    logic [NP-1:0] hit_data_d;
    logic [NB-1:0] result_peak_d;
    logic [15:0]   result_hits_d;
    logic          hit_we_d, his_num_d, his_clr_d, acq_fin_d, busy_d;
    logic          result_valid_d, result_err_d;
    logic          in_window_c, wait_expired_c;

    assign in_window_c    = (tdc_data >= th_minus_q) && (tdc_data <= th_positive_q);
    assign wait_expired_c = (wait_cnt == WAIT_LAST);

    // Next-state and next-output decode
    always_comb begin
        state_d        = state;
        frame_cnt_d    = frame_cnt;
        wait_cnt_d     = '0;
        th_minus_d     = th_minus_q;
        th_positive_d  = th_positive_q;
        clr_addr_d     = '0;
        hit_we_d       = 1'b0;
        hit_data_d     = hit_data;
        his_clr_d      = 1'b0;
        acq_fin_d      = 1'b0;
        result_valid_d = 1'b0;
        result_peak_d  = result_peak;
        result_err_d   = result_err;
        result_hits_d  = result_hits;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d   = CLR_CH;
                    his_clr_d = 1'b1;
                end
            end
            CLR_CH, CLR_FH: begin
                if (clr_addr == CLR_LAST) begin
                    state_d       = (state == CLR_CH) ? CH_ACQ : FH_ACQ;
                    frame_cnt_d   = '0;
                    result_hits_d = '0;
                end else begin
                    his_clr_d  = 1'b1;
                    clr_addr_d = clr_addr + NB'(1);
                end
            end
            CH_ACQ: begin
                if (tdc_valid) begin
                    hit_we_d   = 1'b1;
                    hit_data_d = tdc_data;
                end
                if (laser_sync) begin
                    if (frame_cnt == CH_LAST) begin
                        state_d     = CH_PK;
                        frame_cnt_d = '0;
                        acq_fin_d   = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt + 16'd1;
                    end
                end
            end
            CH_PK: begin
                if (peak_done) begin
                    state_d = CALC;
                end else if (wait_expired_c) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    result_err_d   = 1'b1;
                    result_peak_d  = '0;
                end else begin
                    wait_cnt_d = wait_cnt + WW'(1);
                end
            end
            CALC: begin
                if (alg_ready) begin
                    state_d       = CLR_FH;
                    his_clr_d     = 1'b1;
                    th_minus_d    = th_minus;
                    th_positive_d = th_positive;
                end else if (wait_expired_c) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    result_err_d   = 1'b1;
                    result_peak_d  = '0;
                end else begin
                    wait_cnt_d = wait_cnt + WW'(1);
                end
            end
            FH_ACQ: begin
                if (tdc_valid && in_window_c) begin
                    hit_we_d      = 1'b1;
                    hit_data_d    = tdc_data;
                    result_hits_d = (result_hits == 16'hFFFF) ? result_hits
                                                              : result_hits + 16'd1;
                end
                if (laser_sync) begin
                    if (frame_cnt == FH_LAST) begin
                        state_d     = FH_PK;
                        frame_cnt_d = '0;
                        acq_fin_d   = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt + 16'd1;
                    end
                end
            end
            FH_PK: begin
                if (peak_done) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    result_err_d   = 1'b0;
                    result_peak_d  = peak_fh;
                end else if (wait_expired_c) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    result_err_d   = 1'b1;
                    result_peak_d  = '0;
                end else begin
                    wait_cnt_d = wait_cnt + WW'(1);
                end
            end
            DONE: begin
                if (result_ack) begin
                    state_d = IDLE;
                end else begin
                    result_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything decoded above
        if (abort) begin
            state_d        = IDLE;
            hit_we_d       = 1'b0;
            his_clr_d      = 1'b0;
            acq_fin_d      = 1'b0;
            result_valid_d = 1'b0;
            clr_addr_d     = '0;
            wait_cnt_d     = '0;
        end

        his_num_d = (state_d == CLR_FH) || (state_d == FH_ACQ) || (state_d == FH_PK);
        busy_d    = (state_d != IDLE) && (state_d != DONE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state            <= IDLE;
            frame_cnt        <= '0;
            wait_cnt         <= '0;
            th_minus_q       <= '0;
            th_positive_q    <= '0;
            clr_addr         <= '0;
            hit_we           <= 1'b0;
            hit_data         <= '0;
            his_num          <= 1'b0;
            his_clr          <= 1'b0;
            acq_count_finish <= 1'b0;
            busy             <= 1'b0;
            result_valid     <= 1'b0;
            result_peak      <= '0;
            result_err       <= 1'b0;
            result_hits      <= '0;
        end else begin
            state            <= state_d;
            frame_cnt        <= frame_cnt_d;
            wait_cnt         <= wait_cnt_d;
            th_minus_q       <= th_minus_d;
            th_positive_q    <= th_positive_d;
            clr_addr         <= clr_addr_d;
            hit_we           <= hit_we_d;
            hit_data         <= hit_data_d;
            his_num          <= his_num_d;
            his_clr          <= his_clr_d;
            acq_count_finish <= acq_fin_d;
            busy             <= busy_d;
            result_valid     <= result_valid_d;
            result_peak      <= result_peak_d;
            result_err       <= result_err_d;
            result_hits      <= result_hits_d;
        end
    end

endmodule

// File: tb/tb_dtof_acq_sequencer.sv
// Directed self-checking bench for dtof_acq_sequencer with two frames per pass
// and a short wait limit so the timeout path stays cheap.
module tb_dtof_acq_sequencer;

    localparam int unsigned NP = 10;
    localparam int unsigned NB = 5;

    logic          clk = 1'b0;
    logic          res;
    logic          start, abort, laser_sync, tdc_valid;
    logic [NP-1:0] tdc_data;
    logic          hit_we;
    logic [NP-1:0] hit_data;
    logic          his_num, his_clr;
    logic [NB-1:0] clr_addr;
    logic          acq_count_finish;
    logic          peak_done, alg_ready;
    logic [NP-1:0] th_minus, th_positive;
    logic [NB-1:0] peak_fh;
    logic          busy, result_valid, result_ack;
    logic [NB-1:0] result_peak;
    logic          result_err;
    logic [15:0]   result_hits;

    int tests  = 0;
    int failed = 0;

    dtof_acq_sequencer #(
        .NP(NP), .NB(NB), .CH_FRAMES(2), .FH_FRAMES(2), .TIMEOUT(16)
    ) dut (
        .clk(clk), .res(res), .start(start), .abort(abort),
        .laser_sync(laser_sync), .tdc_valid(tdc_valid), .tdc_data(tdc_data),
        .hit_we(hit_we), .hit_data(hit_data), .his_num(his_num),
        .his_clr(his_clr), .clr_addr(clr_addr),
        .acq_count_finish(acq_count_finish), .peak_done(peak_done),
        .alg_ready(alg_ready), .th_minus(th_minus), .th_positive(th_positive),
        .peak_fh(peak_fh), .busy(busy), .result_valid(result_valid),
        .result_ack(result_ack), .result_peak(result_peak),
        .result_err(result_err), .result_hits(result_hits)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".hit_we"}, 32'(hit_we), 0);
        chk({tag, ".hit_data"}, 32'(hit_data), 0);
        chk({tag, ".his_num"}, 32'(his_num), 0);
        chk({tag, ".his_clr"}, 32'(his_clr), 0);
        chk({tag, ".clr_addr"}, 32'(clr_addr), 0);
        chk({tag, ".acq_fin"}, 32'(acq_count_finish), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".result_valid"}, 32'(result_valid), 0);
        chk({tag, ".result_peak"}, 32'(result_peak), 0);
        chk({tag, ".result_err"}, 32'(result_err), 0);
        chk({tag, ".result_hits"}, 32'(result_hits), 0);
    endtask

    // Called right after the edge that enters a clear state: 32 cycles of his_clr
    task automatic expect_clear(input string tag, input logic hn);
        chk({tag, ".first_clr"}, 32'(his_clr), 1);
        chk({tag, ".first_addr"}, 32'(clr_addr), 0);
        chk({tag, ".his_num"}, 32'(his_num), 32'(hn));
        repeat (31) step;
        chk({tag, ".last_clr"}, 32'(his_clr), 1);
        chk({tag, ".last_addr"}, 32'(clr_addr), 31);
        step;
        chk({tag, ".clr_end"}, 32'(his_clr), 0);
    endtask

    task automatic hit(input string tag, input logic [NP-1:0] d, input logic exp_we);
        tdc_valid = 1'b1;
        tdc_data  = d;
        step;
        tdc_valid = 1'b0;
        chk({tag, ".we"}, 32'(hit_we), 32'(exp_we));
        if (exp_we) chk({tag, ".data"}, 32'(hit_data), 32'(d));
    endtask

    task automatic run_to_ch_pk;
        start = 1'b1;
        step;
        start = 1'b0;
        expect_clear("clr_ch", 1'b0);
        laser_sync = 1'b1;
        step;
        step;
        laser_sync = 1'b0;
        chk("ch_end.acq_fin", 32'(acq_count_finish), 1);
    endtask

    task automatic run_to_fh_acq(input logic [NP-1:0] tm, input logic [NP-1:0] tp);
        run_to_ch_pk();
        peak_done = 1'b1;
        step;
        peak_done   = 1'b0;
        th_minus    = tm;
        th_positive = tp;
        alg_ready   = 1'b1;
        step;
        alg_ready   = 1'b0;
        th_minus    = '0;
        th_positive = 10'd1023;
        expect_clear("clr_fh", 1'b1);
    endtask

    task automatic close_fh;
        laser_sync = 1'b1;
        step;
        step;
        laser_sync = 1'b0;
        chk("fh_end.acq_fin", 32'(acq_count_finish), 1);
    endtask

    initial begin
        res = 1'b0; start = 1'b0; abort = 1'b0; laser_sync = 1'b0;
        tdc_valid = 1'b0; tdc_data = '0; peak_done = 1'b0; alg_ready = 1'b0;
        th_minus = '0; th_positive = '0; peak_fh = '0; result_ack = 1'b0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        res = 1'b1;
        step;

        // Nominal two-pass measurement
        start = 1'b1;
        step;
        start = 1'b0;
        chk("nom.busy", 32'(busy), 1);
        expect_clear("nom.clr_ch", 1'b0);
        hit("nom.ch108", 10'd108, 1'b1);
        chk("nom.ch_his_num", 32'(his_num), 0);
        laser_sync = 1'b1;
        step;
        laser_sync = 1'b0;
        chk("nom.frame1_we", 32'(hit_we), 0);
        chk("nom.frame1_fin", 32'(acq_count_finish), 0);
        tdc_valid = 1'b1; tdc_data = 10'd511; laser_sync = 1'b1;
        step;
        tdc_valid = 1'b0; laser_sync = 1'b0;
        chk("nom.collide_we", 32'(hit_we), 1);
        chk("nom.collide_data", 32'(hit_data), 511);
        chk("nom.collide_fin", 32'(acq_count_finish), 1);
        step;
        chk("nom.fin_pulse", 32'(acq_count_finish), 0);
        chk("nom.we_single", 32'(hit_we), 0);
        step;
        peak_done = 1'b1;
        step;
        peak_done = 1'b0;
        chk("nom.calc_busy", 32'(busy), 1);
        th_minus = 10'd100; th_positive = 10'd120; alg_ready = 1'b1;
        step;
        alg_ready = 1'b0; th_minus = '0; th_positive = 10'd1023;
        expect_clear("nom.clr_fh", 1'b1);
        hit("nom.fh90", 10'd90, 1'b0);
        hit("nom.fh108", 10'd108, 1'b1);
        chk("nom.fh_his_num", 32'(his_num), 1);
        laser_sync = 1'b1;
        step;
        laser_sync = 1'b0;
        hit("nom.fh110", 10'd110, 1'b1);
        tdc_valid = 1'b1; tdc_data = 10'd500; laser_sync = 1'b1;
        step;
        tdc_valid = 1'b0; laser_sync = 1'b0;
        chk("nom.fh500_we", 32'(hit_we), 0);
        chk("nom.fh_fin", 32'(acq_count_finish), 1);
        peak_fh = 5'd12; peak_done = 1'b1;
        step;
        peak_done = 1'b0; peak_fh = 5'd3;
        chk("nom.valid", 32'(result_valid), 1);
        chk("nom.peak", 32'(result_peak), 12);
        chk("nom.err", 32'(result_err), 0);
        chk("nom.hits", 32'(result_hits), 2);
        chk("nom.busy_done", 32'(busy), 0);

        // Hold the result without ack; a start in DONE must not restart
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            step;
            start = 1'b0;
            chk("hs.valid_hold", 32'(result_valid), 1);
            chk("hs.peak_hold", 32'(result_peak), 12);
            chk("hs.no_clr", 32'(his_clr), 0);
        end
        result_ack = 1'b1;
        step;
        result_ack = 1'b0;
        chk("hs.ack_valid", 32'(result_valid), 0);
        chk("hs.ack_busy", 32'(busy), 0);
        step;
        chk("hs.idle_clr", 32'(his_clr), 0);

        // Peak detector never answers in CH_PK
        run_to_ch_pk();
        repeat (15) step;
        chk("to.valid_early", 32'(result_valid), 0);
        chk("to.busy_early", 32'(busy), 1);
        step;
        chk("to.valid", 32'(result_valid), 1);
        chk("to.err", 32'(result_err), 1);
        chk("to.peak", 32'(result_peak), 0);
        result_ack = 1'b1;
        step;
        result_ack = 1'b0;
        chk("to.ack", 32'(result_valid), 0);

        // Abort during FH acquisition, then a clean measurement
        run_to_fh_acq(10'd100, 10'd120);
        tdc_valid = 1'b1; tdc_data = 10'd110; abort = 1'b1;
        step;
        tdc_valid = 1'b0; abort = 1'b0;
        chk("ab.busy", 32'(busy), 0);
        chk("ab.hit_we", 32'(hit_we), 0);
        chk("ab.his_num", 32'(his_num), 0);
        step;
        chk("ab.idle", 32'(his_clr), 0);
        run_to_fh_acq(10'd100, 10'd120);
        hit("ab2.fh110", 10'd110, 1'b1);
        hit("ab2.fh121", 10'd121, 1'b0);
        hit("ab2.fh100", 10'd100, 1'b1);
        close_fh();
        peak_fh = 5'd7; peak_done = 1'b1;
        step;
        peak_done = 1'b0;
        chk("ab2.valid", 32'(result_valid), 1);
        chk("ab2.peak", 32'(result_peak), 7);
        chk("ab2.err", 32'(result_err), 0);
        chk("ab2.hits", 32'(result_hits), 2);
        result_ack = 1'b1;
        step;
        result_ack = 1'b0;

        // Inverted thresholds: empty window
        run_to_fh_acq(10'd200, 10'd100);
        hit("ew.150", 10'd150, 1'b0);
        hit("ew.200", 10'd200, 1'b0);
        hit("ew.100", 10'd100, 1'b0);
        close_fh();
        peak_fh = 5'd3; peak_done = 1'b1;
        step;
        peak_done = 1'b0;
        chk("ew.valid", 32'(result_valid), 1);
        chk("ew.hits", 32'(result_hits), 0);
        chk("ew.peak", 32'(result_peak), 3);
        result_ack = 1'b1;
        step;
        result_ack = 1'b0;

        // Asynchronous reset on a falling edge mid-pass
        run_to_fh_acq(10'd100, 10'd120);
        hit("ar.fh110", 10'd110, 1'b1);
        chk("ar.busy", 32'(busy), 1);
        @(negedge clk);
        res = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        res = 1'b1;
        step;
        chk("ar.after_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
